// File: rtl/seq_alu_if.sv
// Operand/result bundle for the sequential ALU.
// The master drives the request; the slave drives the result and the handshake.
interface seq_alu_if #(
  parameter int unsigned WIDTH = 4
);
  logic               start;
  logic [3:0]         mode;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [2*WIDTH-1:0] out;
  logic [WIDTH-1:0]   rem;
  logic               neg;
  logic               err;
  logic               busy;
  logic               done;

  modport master (
    output start, mode, a, b,
    input  out, rem, neg, err, busy, done
  );

  modport slave (
    input  start, mode, a, b,
    output out, rem, neg, err, busy, done
  );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle ADD/SUB, shift-add MUL and restoring DIV,
// with a sign-magnitude result and a start/busy/done handshake.
module seq_alu #(
  parameter int unsigned WIDTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  seq_alu_if.slave   bus
);
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] MODE_ADD = 4'd1;
  localparam logic [3:0] MODE_SUB = 4'd2;
  localparam logic [3:0] MODE_MUL = 4'd3;
  localparam logic [3:0] MODE_DIV = 4'd4;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [3:0]         mode_q, mode_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               neg_q, neg_d;
  logic               err_q, err_d;

  logic               last;
  logic [2*WIDTH-1:0] mul_acc;
  logic [WIDTH:0]     div_trial;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [WIDTH-1:0]   div_quo;

  assign last = (cnt_q == CW'(WIDTH - 1));

  // MUL: a_q<<i sits in mcand_q and b_q shifts right, so b_q[0] is multiplier bit i.
  assign mul_acc = acc_q + (b_q[0] ? mcand_q : '0);

  // DIV: acc_q[WIDTH-1:0] is the partial remainder; a_q shifts dividend bits out
  // of its MSB while quotient bits enter its LSB.
  assign div_trial = {acc_q[WIDTH-1:0], a_q[WIDTH-1]};
  assign div_ge    = (div_trial >= {1'b0, b_q});
  assign div_rem   = div_ge ? WIDTH'(div_trial - {1'b0, b_q}) : div_trial[WIDTH-1:0];
  assign div_quo   = {a_q[WIDTH-2:0], div_ge};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    a_d     = a_q;
    b_d     = b_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    out_d   = out_q;
    rem_d   = rem_q;
    neg_d   = neg_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = CALC;
          cnt_d   = '0;
          mode_d  = bus.mode;
          a_d     = bus.a;
          b_d     = bus.b;
          mcand_d = {{WIDTH{1'b0}}, bus.a};
          acc_d   = '0;
        end
      end

      CALC: begin
        cnt_d = cnt_q + CW'(1);
        rem_d = '0;
        neg_d = 1'b0;
        err_d = 1'b0;
        case (mode_q)
          MODE_ADD: begin
            state_d = DONE;
            out_d   = {{(WIDTH-1){1'b0}}, {1'b0, a_q} + {1'b0, b_q}};
          end
          MODE_SUB: begin
            state_d = DONE;
            neg_d   = (b_q > a_q);
            out_d   = {{WIDTH{1'b0}}, (b_q > a_q) ? (b_q - a_q) : (a_q - b_q)};
          end
          MODE_MUL: begin
            acc_d   = mul_acc;
            mcand_d = mcand_q << 1;
            b_d     = b_q >> 1;
            if (last) begin
              state_d = DONE;
              out_d   = mul_acc;
            end else begin
              rem_d = rem_q;
              neg_d = neg_q;
              err_d = err_q;
            end
          end
          MODE_DIV: begin
            if (b_q == '0) begin
              state_d = DONE;
              out_d   = '0;
              err_d   = 1'b1;
            end else begin
              acc_d = {{WIDTH{1'b0}}, div_rem};
              a_d   = div_quo;
              if (last) begin
                state_d = DONE;
                out_d   = {{WIDTH{1'b0}}, div_quo};
                rem_d   = div_rem;
              end else begin
                rem_d = rem_q;
                neg_d = neg_q;
                err_d = err_q;
              end
            end
          end
          default: begin
            state_d = DONE;
            out_d   = '0;
            err_d   = 1'b1;
          end
        endcase
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      rem_q   <= '0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      rem_q   <= rem_d;
      neg_q   <= neg_d;
      err_q   <= err_d;
    end
  end

  assign bus.out  = out_q;
  assign bus.rem  = rem_q;
  assign bus.neg  = neg_q;
  assign bus.err  = err_q;
  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: WIDTH=4 instance for all modes, handshake and
// reset cases, plus a WIDTH=8 instance for the wide multiply.
module tb_seq_alu;
  logic clk;
  logic rst;
  int   ncmp;
  int   nfail;

  seq_alu_if #(.WIDTH(4)) bus ();
  seq_alu_if #(.WIDTH(8)) bus8 ();

  seq_alu #(.WIDTH(4)) dut  (.clk(clk), .rst(rst), .bus(bus));
  seq_alu #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, string what, logic [31:0] obs, logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s.%s observed=%0d expected=%0d", tag, what, obs, exp);
    end
  endtask

  // Issues one request, scrambles the inputs after the accepting edge, and
  // checks latency (edges from accept to done) and the latched result.
  task automatic do_op(string tag, logic [3:0] m, logic [3:0] av, logic [3:0] bv,
                       int lat, logic [7:0] eo, logic [3:0] er, logic en, logic ee);
    int n;
    bus.mode  = m;
    bus.a     = av;
    bus.b     = bv;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a     = ~av;
    bus.b     = ~bv;
    bus.mode  = 4'd1;
    chk(tag, "busy", bus.busy, 1);
    n = 0;
    while (!bus.done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, "latency", n, lat);
    chk(tag, "out", bus.out, eo);
    chk(tag, "rem", bus.rem, er);
    chk(tag, "neg", bus.neg, en);
    chk(tag, "err", bus.err, ee);
    @(posedge clk); #1;
    chk(tag, "done_drop", bus.done, 0);
    chk(tag, "idle", bus.busy, 0);
  endtask

  initial begin
    int n;
    int pulses;
    ncmp  = 0;
    nfail = 0;
    rst   = 1'b0;
    bus.start  = 1'b0; bus.mode  = '0; bus.a  = '0; bus.b  = '0;
    bus8.start = 1'b0; bus8.mode = '0; bus8.a = '0; bus8.b = '0;
    #1 rst = 1'b1;
    #2;
    chk("reset", "out", bus.out, 0);
    chk("reset", "busy", bus.busy, 0);
    chk("reset", "done", bus.done, 0);
    chk("reset", "err", bus.err, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    do_op("add9_7",   4'd1, 4'd9,  4'd7,  1, 8'd16,  4'd0, 1'b0, 1'b0);
    do_op("add15_15", 4'd1, 4'd15, 4'd15, 1, 8'd30,  4'd0, 1'b0, 1'b0);
    do_op("sub3_8",   4'd2, 4'd3,  4'd8,  1, 8'd5,   4'd0, 1'b1, 1'b0);
    do_op("sub8_3",   4'd2, 4'd8,  4'd3,  1, 8'd5,   4'd0, 1'b0, 1'b0);
    do_op("sub6_6",   4'd2, 4'd6,  4'd6,  1, 8'd0,   4'd0, 1'b0, 1'b0);
    do_op("mul15_15", 4'd3, 4'd15, 4'd15, 4, 8'd225, 4'd0, 1'b0, 1'b0);
    do_op("mul13_11", 4'd3, 4'd13, 4'd11, 4, 8'd143, 4'd0, 1'b0, 1'b0);
    do_op("mul0_9",   4'd3, 4'd0,  4'd9,  4, 8'd0,   4'd0, 1'b0, 1'b0);
    do_op("div13_4",  4'd4, 4'd13, 4'd4,  4, 8'd3,   4'd1, 1'b0, 1'b0);
    do_op("div3_7",   4'd4, 4'd3,  4'd7,  4, 8'd0,   4'd3, 1'b0, 1'b0);
    do_op("div15_1",  4'd4, 4'd15, 4'd1,  4, 8'd15,  4'd0, 1'b0, 1'b0);
    do_op("div9_0",   4'd4, 4'd9,  4'd0,  1, 8'd0,   4'd0, 1'b0, 1'b1);
    do_op("add1_2",   4'd1, 4'd1,  4'd2,  1, 8'd3,   4'd0, 1'b0, 1'b0);
    do_op("mode15",   4'd15, 4'd5, 4'd3,  1, 8'd0,   4'd0, 1'b0, 1'b1);
    do_op("mode0",    4'd0, 4'd5,  4'd3,  1, 8'd0,   4'd0, 1'b0, 1'b1);
    do_op("sub7_2",   4'd2, 4'd7,  4'd2,  1, 8'd5,   4'd0, 1'b0, 1'b0);

    // Wide multiply on the WIDTH=8 instance.
    bus8.mode = 4'd3; bus8.a = 8'd255; bus8.b = 8'd255; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0; bus8.a = 8'd1; bus8.b = 8'd1;
    n = 0;
    while (!bus8.done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("mul8", "latency", n, 8);
    chk("mul8", "out", bus8.out, 65025);
    chk("mul8", "err", bus8.err, 0);
    @(posedge clk); #1;

    // start held high: second request must be taken two edges after done rises.
    bus.mode = 4'd1; bus.a = 4'd3; bus.b = 4'd5; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.a = 4'd1; bus.b = 4'd1;
    @(posedge clk); #1;
    chk("hold", "done1", bus.done, 1);
    chk("hold", "out1", bus.out, 8);
    @(posedge clk); #1;
    chk("hold", "idle_gap", bus.busy, 0);
    chk("hold", "out_held", bus.out, 8);
    bus.a = 4'd9; bus.b = 4'd2;
    @(posedge clk); #1;
    chk("hold", "accept2", bus.busy, 1);
    chk("hold", "out_held2", bus.out, 8);
    bus.start = 1'b0; bus.a = 4'd0; bus.b = 4'd0;
    @(posedge clk); #1;
    chk("hold", "done2", bus.done, 1);
    chk("hold", "out2", bus.out, 11);
    @(posedge clk); #1;

    // Reset during the second DIV iteration.
    bus.mode = 4'd4; bus.a = 4'd13; bus.b = 4'd4; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_mid", "out", bus.out, 0);
    chk("rst_mid", "rem", bus.rem, 0);
    chk("rst_mid", "busy", bus.busy, 0);
    chk("rst_mid", "done", bus.done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) pulses++;
    end
    chk("rst_mid", "no_activity", pulses, 0);
    do_op("div_after_rst", 4'd4, 4'd13, 4'd4, 4, 8'd3, 4'd1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
